// File: rtl/instruction_queue_decode.sv
// Instruction queue with head decode.
// Buffers fetched {instruction, PC} pairs in a small FIFO with valid/ready on both
// sides and splits the head entry into register indices, opcodes, immediates and
// class flags for the register-read/ALU control stage. A synchronous flush drops
// everything in flight when a branch or jump is taken.

module instruction_queue_decode #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned IMM_BITS = 8,
  parameter int unsigned OP_BITS  = 4,
  parameter int unsigned REG_BITS = 4,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  // Fetch side
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_instruction,
  input  logic [WIDTH-1:0]    in_pc,
  // Consumer side
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_instruction,
  output logic [WIDTH-1:0]    out_pc,
  // Head decode
  output logic [OP_BITS-1:0]  op_code,
  output logic [OP_BITS-1:0]  ext_op_code,
  output logic [REG_BITS-1:0] a_index,
  output logic [REG_BITS-1:0] b_index,
  output logic [WIDTH-1:0]    imm_zext,
  output logic [WIDTH-1:0]    imm_sext,
  output logic                is_immediate,
  output logic                is_alu_non_immediate,
  output logic                is_bcond,
  output logic                is_load,
  output logic                is_store,
  output logic                is_jcond,
  output logic                is_shift,
  output logic [CNT_BITS-1:0] occupancy
);

  localparam int unsigned PtrBits = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Opcode encodings for the instruction classes the control stage cares about.
  localparam logic [OP_BITS-1:0] OpAlu   = OP_BITS'(4'b0000);
  localparam logic [OP_BITS-1:0] OpMem   = OP_BITS'(4'b0100);
  localparam logic [OP_BITS-1:0] OpShift = OP_BITS'(4'b1000);
  localparam logic [OP_BITS-1:0] OpBcond = OP_BITS'(4'b1100);
  localparam logic [OP_BITS-1:0] ExtLoad  = OP_BITS'(4'b0000);
  localparam logic [OP_BITS-1:0] ExtStore = OP_BITS'(4'b0100);
  localparam logic [OP_BITS-1:0] ExtJcond = OP_BITS'(4'b1100);

  // --------------------------------------------------------------------------
  // Storage and pointers
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]    r_mem_instr [DEPTH];
  logic [WIDTH-1:0]    r_mem_pc    [DEPTH];
  logic [PtrBits-1:0]  r_rd_ptr;
  logic [PtrBits-1:0]  r_wr_ptr;
  logic [CNT_BITS-1:0] r_count;

  logic                w_push;
  logic                w_pop;
  logic [PtrBits-1:0]  w_rd_ptr_inc;
  logic [PtrBits-1:0]  w_wr_ptr_inc;
  logic [CNT_BITS-1:0] w_count_next;

  // Handshake status comes only from registered occupancy: a pop cannot free a
  // slot for a push in the same cycle, which keeps out_ready off the in_ready path.
  always_comb begin
    in_ready  = (r_count != CNT_BITS'(DEPTH));
    out_valid = (r_count != '0);
    occupancy = r_count;
    w_push    = in_valid & in_ready;
    w_pop     = out_valid & out_ready;
  end

  // Pointer increments with explicit wrap at DEPTH-1.
  always_comb begin
    w_rd_ptr_inc = (r_rd_ptr == PtrBits'(DEPTH - 1)) ? '0 : r_rd_ptr + PtrBits'(1);
    w_wr_ptr_inc = (r_wr_ptr == PtrBits'(DEPTH - 1)) ? '0 : r_wr_ptr + PtrBits'(1);
  end

  // Occupancy next state; simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_count_next = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_BITS'(1);
      2'b01:   w_count_next = r_count - CNT_BITS'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Pointer and count registers; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_inc;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      r_count <= w_count_next;
    end
  end

  // Data array write; not reset, and a push coinciding with flush is dropped.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem_instr[r_wr_ptr] <= in_instruction;
      r_mem_pc[r_wr_ptr]    <= in_pc;
    end
  end

  // Head entry is read straight from storage; no bypass from the fetch side.
  always_comb begin
    out_instruction = r_mem_instr[r_rd_ptr];
    out_pc          = r_mem_pc[r_rd_ptr];
  end

  // --------------------------------------------------------------------------
  // Head decode
  // --------------------------------------------------------------------------
  logic [OP_BITS-1:0]  w_op;
  logic [OP_BITS-1:0]  w_ext;
  logic [REG_BITS-1:0] w_a;
  logic [REG_BITS-1:0] w_b;
  logic [IMM_BITS-1:0] w_imm;

  // Raw field split of the head instruction.
  always_comb begin
    w_op  = out_instruction[WIDTH-1 -: OP_BITS];
    w_a   = out_instruction[WIDTH-OP_BITS-1 -: REG_BITS];
    w_ext = out_instruction[REG_BITS +: OP_BITS];
    w_b   = out_instruction[REG_BITS-1:0];
    w_imm = out_instruction[IMM_BITS-1:0];
  end

  // Decoded outputs, forced to zero whenever the head entry is not valid so that
  // stale storage contents never leak out as a spurious instruction class.
  always_comb begin
    op_code              = '0;
    ext_op_code          = '0;
    a_index              = '0;
    b_index              = '0;
    imm_zext             = '0;
    imm_sext             = '0;
    is_immediate         = 1'b0;
    is_alu_non_immediate = 1'b0;
    is_bcond             = 1'b0;
    is_load              = 1'b0;
    is_store             = 1'b0;
    is_jcond             = 1'b0;
    is_shift             = 1'b0;
    if (out_valid) begin
      op_code              = w_op;
      ext_op_code          = w_ext;
      a_index              = w_a;
      b_index              = w_b;
      imm_zext             = {{(WIDTH - IMM_BITS){1'b0}}, w_imm};
      imm_sext             = {{(WIDTH - IMM_BITS){w_imm[IMM_BITS-1]}}, w_imm};
      is_immediate         = (w_op[1:0] != 2'b00);
      is_alu_non_immediate = (w_op == OpAlu);
      is_bcond             = (w_op == OpBcond);
      is_shift             = (w_op == OpShift);
      // Memory/jump group: the ext opcode selects exactly one class, or none.
      is_load              = (w_op == OpMem) && (w_ext == ExtLoad);
      is_store             = (w_op == OpMem) && (w_ext == ExtStore);
      is_jcond             = (w_op == OpMem) && (w_ext == ExtJcond);
    end
  end

endmodule

// File: tb/tb_instruction_queue_decode.sv
// Bench for instruction_queue_decode: directed scenarios with literal expectations,
// then randomized traffic, all checked each cycle against a queue-based model.

module tb_instruction_queue_decode;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned DEPTH    = 2;
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

  logic                clk;
  logic                reset_n;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_instruction;
  logic [WIDTH-1:0]    in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_instruction;
  logic [WIDTH-1:0]    out_pc;
  logic [3:0]          op_code;
  logic [3:0]          ext_op_code;
  logic [3:0]          a_index;
  logic [3:0]          b_index;
  logic [WIDTH-1:0]    imm_zext;
  logic [WIDTH-1:0]    imm_sext;
  logic                is_immediate;
  logic                is_alu_non_immediate;
  logic                is_bcond;
  logic                is_load;
  logic                is_store;
  logic                is_jcond;
  logic                is_shift;
  logic [CNT_BITS-1:0] occupancy;

  instruction_queue_decode #(
    .WIDTH   (WIDTH),
    .IMM_BITS(8),
    .OP_BITS (4),
    .REG_BITS(4),
    .DEPTH   (DEPTH)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .flush               (flush),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_instruction      (in_instruction),
    .in_pc               (in_pc),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_instruction     (out_instruction),
    .out_pc              (out_pc),
    .op_code             (op_code),
    .ext_op_code         (ext_op_code),
    .a_index             (a_index),
    .b_index             (b_index),
    .imm_zext            (imm_zext),
    .imm_sext            (imm_sext),
    .is_immediate        (is_immediate),
    .is_alu_non_immediate(is_alu_non_immediate),
    .is_bcond            (is_bcond),
    .is_load             (is_load),
    .is_store            (is_store),
    .is_jcond            (is_jcond),
    .is_shift            (is_shift),
    .occupancy           (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of {pc, instruction}.
  logic [31:0] q[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
    end else begin
      automatic bit do_push = in_valid && (q.size() < DEPTH);
      automatic bit do_pop  = out_ready && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back({in_pc, in_instruction});
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (reset_n) begin
      automatic int n = q.size();
      check("occupancy", 32'(occupancy), 32'(n));
      check("in_ready", 32'(in_ready), 32'(n != DEPTH));
      check("out_valid", 32'(out_valid), 32'(n != 0));
      if (n != 0) begin
        automatic int ins = int'(q[0][15:0]);
        automatic int pc  = int'(q[0][31:16]);
        automatic int op  = (ins >> 12) & 15;
        automatic int ra  = (ins >> 8) & 15;
        automatic int ext = (ins >> 4) & 15;
        automatic int rb  = ins & 15;
        automatic int imm = ins & 255;
        automatic int sx  = (imm >= 128) ? imm + 32'hFF00 : imm;
        check("out_instruction", 32'(out_instruction), 32'(ins));
        check("out_pc", 32'(out_pc), 32'(pc));
        check("op_code", 32'(op_code), 32'(op));
        check("a_index", 32'(a_index), 32'(ra));
        check("ext_op_code", 32'(ext_op_code), 32'(ext));
        check("b_index", 32'(b_index), 32'(rb));
        check("imm_zext", 32'(imm_zext), 32'(imm));
        check("imm_sext", 32'(imm_sext), 32'(sx));
        check("is_immediate", 32'(is_immediate), 32'((op % 4) != 0));
        check("is_alu_non_imm", 32'(is_alu_non_immediate), 32'(op == 0));
        check("is_bcond", 32'(is_bcond), 32'(op == 12));
        check("is_shift", 32'(is_shift), 32'(op == 8));
        check("is_load", 32'(is_load), 32'(op == 4 && ext == 0));
        check("is_store", 32'(is_store), 32'(op == 4 && ext == 4));
        check("is_jcond", 32'(is_jcond), 32'(op == 4 && ext == 12));
      end else begin
        check("idle_decode", {op_code, ext_op_code, a_index, b_index, 16'h0},
              32'h0);
        check("idle_imm", {imm_zext, imm_sext}, 32'h0);
        check("idle_flags", 32'({is_immediate, is_alu_non_immediate, is_bcond, is_load,
                                 is_store, is_jcond, is_shift}), 32'h0);
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic rdy, input logic fl);
    in_valid       = v;
    in_instruction = ins;
    in_pc          = pc;
    out_ready      = rdy;
    flush          = fl;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instruction = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset / idle
    check("t1_out_valid", 32'(out_valid), 32'h0);
    check("t1_in_ready", 32'(in_ready), 32'h1);
    check("t1_occupancy", 32'(occupancy), 32'h0);
    check("t1_alu_flag", 32'(is_alu_non_immediate), 32'h0);

    // Single immediate-form instruction
    drive(1, 16'h5A3C, 16'h0010, 1, 0);
    check("t2_valid", 32'(out_valid), 32'h1);
    check("t2_fields", {16'h0, op_code, a_index, b_index, ext_op_code}, 32'h5AC3);
    check("t2_pc", 32'(out_pc), 32'h0010);
    check("t2_imm", {imm_zext, imm_sext}, 32'h003C_003C);
    check("t2_is_imm", 32'(is_immediate), 32'h1);
    drive(0, 16'h0, 16'h0, 1, 0);
    check("t2_popped", 32'(out_valid), 32'h0);

    // Branch, store, load
    drive(1, 16'hC1F0, 16'h0020, 1, 0);
    check("t3_bcond", 32'({is_bcond, is_immediate}), 32'h2);
    check("t3_imm", {imm_sext, imm_zext}, 32'hFFF0_00F0);
    drive(1, 16'h4C41, 16'h0022, 1, 0);
    check("t3_store", 32'({is_load, is_store, is_jcond}), 32'h2);
    check("t3_idx", 32'({a_index, b_index}), 32'hC1);
    drive(1, 16'h4200, 16'h0024, 1, 0);
    check("t3_load", 32'({is_load, is_store, is_jcond}), 32'h4);
    drive(0, 16'h0, 16'h0, 1, 0);

    // Backpressure on full queue
    drive(1, 16'h1111, 16'h0100, 0, 0);
    drive(1, 16'h2222, 16'h0102, 0, 0);
    check("t4_in_ready", 32'(in_ready), 32'h0);
    check("t4_occ", 32'(occupancy), 32'h2);
    drive(1, 16'h3333, 16'h0104, 0, 0);
    check("t4_hold", 32'(out_instruction), 32'h1111);
    drive(1, 16'h3333, 16'h0104, 1, 0);
    check("t4_second", 32'(out_instruction), 32'h2222);
    check("t4_occ1", 32'(occupancy), 32'h1);
    drive(1, 16'h3333, 16'h0104, 1, 0);
    check("t4_third", 32'(out_instruction), 32'h3333);
    drive(0, 16'h0, 16'h0, 1, 0);
    check("t4_empty", 32'(occupancy), 32'h0);

    // Streaming across pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(1, 16'(16'h0100 + i), 16'(16'h0200 + 2 * i), 1, 0);
      check("t5_stream", {16'(occupancy), out_instruction}, 32'h0001_0100 + 32'(i));
    end
    drive(0, 16'h0, 16'h0, 1, 0);

    // Flush with a full queue, then flush overriding a concurrent push
    drive(1, 16'hAAAA, 16'h0300, 0, 0);
    drive(1, 16'hBBBB, 16'h0302, 0, 0);
    drive(1, 16'hCCCC, 16'h0304, 0, 1);
    check("t6_flush_full", 32'({out_valid, 2'(occupancy)}), 32'h0);
    drive(1, 16'hDDDD, 16'h0306, 0, 0);
    in_valid = 1'b1; in_instruction = 16'hEEEE; flush = 1'b1;
    check("t6_ready_in_flush", 32'(in_ready), 32'h1);
    @(negedge clk);
    check("t6_flush_push", 32'({out_valid, 2'(occupancy)}), 32'h0);

    // Asynchronous reset mid-stream
    drive(1, 16'h7777, 16'h0400, 0, 0);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 check("t6_async_valid", 32'(out_valid), 32'h0);
    check("t6_async_occ", 32'(occupancy), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, 16'($urandom), 16'($urandom), ($urandom % 3) != 0,
            ($urandom % 40) == 0);
    end
    drive(0, 16'h0, 16'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_queue_decode.md
Name: instruction_queue_decode

Overview:
- Parametrised successor to the combinational instruction field splitter.
- Buffers fetched instructions, with their PC, in a DEPTH-entry FIFO using valid/ready handshakes on both sides.
- Decodes the head entry into fields, sign- and zero-extended immediates, and instruction-class flags.
- Sits between fetch and the register-read/ALU control stage; a synchronous flush discards in-flight instructions on taken branches and jumps.

Parameters:
- WIDTH, 16, instruction and PC width in bits
- IMM_BITS, 8, immediate field width (instruction[IMM_BITS-1:0])
- OP_BITS, 4, opcode and extended-opcode width
- REG_BITS, 4, register index width
- DEPTH, 2, FIFO entries; power of two, 2..8
- CNT_BITS, $clog2(DEPTH+1), occupancy counter width

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous discard of all entries
- in_valid  input  1  fetch presents instruction
- in_ready  output  1  queue can accept
- in_instruction  input  WIDTH  fetched instruction
- in_pc  input  WIDTH  address of in_instruction
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head
- out_instruction  output  WIDTH  head instruction
- out_pc  output  WIDTH  head PC
- op_code  output  OP_BITS  instruction[15:12]
- ext_op_code  output  OP_BITS  instruction[7:4]
- a_index  output  REG_BITS  instruction[11:8]
- b_index  output  REG_BITS  instruction[3:0]
- imm_zext  output  WIDTH  immediate zero-extended
- imm_sext  output  WIDTH  immediate sign-extended from bit IMM_BITS-1
- is_immediate  output  1  op_code[1:0] != 0
- is_alu_non_immediate  output  1  op_code == 0000
- is_bcond  output  1  op_code == 1100
- is_load  output  1  op 0100, ext 0000
- is_store  output  1  op 0100, ext 0100
- is_jcond  output  1  op 0100, ext 1100
- is_shift  output  1  op_code == 1000
- occupancy  output  CNT_BITS  entries held

Behaviour:
- Reset (async, reset_n=0):
  - read pointer, write pointer and count go to 0.
  - out_valid=0, in_ready=1, occupancy=0.
  - Storage array is not reset.
- Push and pop:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready = (count != DEPTH), registered-state only; no combinational path from out_ready. When full, a simultaneous pop does not enable a push that cycle.
- out_valid = (count != 0).
- Latency: an instruction pushed at edge N is presented with out_valid=1 after edge N. There is no same-cycle bypass.
- FIFO order is strict.
- Pointers wrap modulo DEPTH.
- Count update on each edge:
  - push and pop together: count unchanged.
  - push only: count+1.
  - pop only: count-1.
- out_instruction and out_pc come from storage[read pointer].
- All decode outputs are combinational from out_instruction, gated by out_valid. When out_valid=0, every field, immediate and flag is 0.
- imm_sext: the WIDTH-IMM_BITS upper bits replicate instruction[IMM_BITS-1]. imm_zext: upper bits are 0.
- is_load, is_store and is_jcond are mutually exclusive. Other ext values under op 0100 assert none of them.
- flush=1 at an edge:
  - pointers and count go to 0.
  - It overrides a push or pop in the same cycle; the pushed instruction is discarded.
  - in_ready stays 1 during the flush cycle, because it is derived from the pre-flush count.
- Reset asserted mid-operation clears state immediately (asynchronous); outputs follow within the same cycle.
- Holding rule: while out_valid=1 and out_ready=0, out_instruction, out_pc and all decode outputs stay stable.

Test Plan:
1. Reset, then idle -> out_valid=0, in_ready=1, occupancy=0, all decode outputs 0.
2. Push 0x5A3C at PC 0x0010, out_ready=1 -> next cycle:
   - out_valid=1, op_code=5, a_index=A, b_index=C, ext_op_code=3.
   - imm_zext=imm_sext=0x003C, is_immediate=1.
   - Popped the following edge.
3. Push 0xC1F0, out_ready=1 -> is_bcond=1, is_immediate=0, imm_sext=0xFFF0, imm_zext=0x00F0.
   - Then push 0x4C41 -> is_store=1, a_index=C, b_index=1.
   - Then push 0x4200 -> is_load=1.
4. out_ready=0, push 0x1111, 0x2222, then offer 0x3333 (DEPTH=2):
   - in_ready=0 after the second push; occupancy=2; 0x3333 is held off.
   - Raise out_ready -> outputs 0x1111 then 0x2222 in order, then 0x3333 accepted.
5. Steady state with in_valid=out_ready=1 each cycle -> occupancy constant at 1, one instruction out per cycle, order preserved across pointer wrap over 10 instructions.
6. Flush:
   - With occupancy=2 and a concurrent push -> next cycle occupancy=0, out_valid=0, pushed instruction lost.
   - reset_n pulsed low mid-stream -> out_valid drops without waiting for a clock edge.
